// File: rtl/decrypt_pkg.sv
// decrypt_pkg
//   Shared types and default widths for the LWE decrypt sequencer.
//   state_t        : controller state encoding (all four codes used)
//   DEF_*          : default parameter values for decrypt_ctrl
package decrypt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int DEF_DIMENSION        = 1;
    localparam int DEF_CIPHERTEXT_WIDTH = 21;
    localparam int DEF_PLAINTEXT_WIDTH  = 6;
    localparam int DEF_ADDR_WIDTH       = 8;
    localparam int DEF_DECRYPT_LATENCY  = 1;

endpackage

// File: rtl/decrypt_ctrl.sv
// decrypt_ctrl
//   Sequencer for the LWE decrypt datapath. Takes a ciphertext base address,
//   streams DIMENSION+1 SK/CT entry pairs from two 1-cycle-latency ROMs into
//   the decrypt block (row 0..DIMENSION), waits out the datapath latency and
//   then holds the captured plaintext until the consumer takes it.
//
//   Handshakes (both sides): a transfer happens on a rising clk edge where
//   valid and ready are both high. The controller never depends on the
//   partner's valid/ready to raise its own; req_ready is high only in IDLE,
//   res_valid only in DONE, and res_data is stable while res_valid is high.
//
//   Ports
//     clk, rst_n        clock, asynchronous active-low reset
//     req_valid/ready   request handshake, req_ct_base = CT base address
//     mem_rd_en         read strobe shared by SK and CT memories
//     sk_addr, ct_addr  entry index / base+index (wraps mod 2^ADDR_WIDTH)
//     sk_rdata,ct_rdata memory data, one cycle after mem_rd_en
//     dec_skentry/ctentry/row  feed to decrypt (row aligned with rdata)
//     dec_result        plaintext from decrypt
//     res_valid/ready   result handshake, res_data = captured plaintext
//     done_count        completed decrypts, wraps at 2^16
//     dbg_state         current controller state
module decrypt_ctrl
    import decrypt_pkg::*;
#(
    parameter int DIMENSION        = DEF_DIMENSION,
    parameter int CIPHERTEXT_WIDTH = DEF_CIPHERTEXT_WIDTH,
    parameter int PLAINTEXT_WIDTH  = DEF_PLAINTEXT_WIDTH,
    parameter int ADDR_WIDTH       = DEF_ADDR_WIDTH,
    parameter int DECRYPT_LATENCY  = DEF_DECRYPT_LATENCY
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [ADDR_WIDTH-1:0]       req_ct_base,
    output logic                        mem_rd_en,
    output logic [ADDR_WIDTH-1:0]       sk_addr,
    output logic [ADDR_WIDTH-1:0]       ct_addr,
    input  logic [CIPHERTEXT_WIDTH-1:0] sk_rdata,
    input  logic [CIPHERTEXT_WIDTH-1:0] ct_rdata,
    output logic [CIPHERTEXT_WIDTH-1:0] dec_skentry,
    output logic [CIPHERTEXT_WIDTH-1:0] dec_ctentry,
    output logic [DIMENSION:0]          dec_row,
    input  logic [PLAINTEXT_WIDTH-1:0]  dec_result,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [PLAINTEXT_WIDTH-1:0]  res_data,
    output logic [15:0]                 done_count,
    output state_t                      dbg_state
);

    localparam int ROW_W = DIMENSION + 1;
    localparam int CNT_W = (DECRYPT_LATENCY < 2) ? 1 : $clog2(DECRYPT_LATENCY + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(DIMENSION);
    localparam logic [CNT_W-1:0]      WAIT_LOAD = CNT_W'(DECRYPT_LATENCY);

    state_t                       r_state;
    state_t                       w_next_state;
    logic [ADDR_WIDTH-1:0]        r_idx;
    logic [ADDR_WIDTH-1:0]        r_base;
    logic [CNT_W-1:0]             r_wait_cnt;
    logic [DIMENSION:0]           r_dec_row;
    logic [PLAINTEXT_WIDTH-1:0]   r_res_data;
    logic [15:0]                  r_done_count;
    logic                         w_last_read;
    logic                         w_wait_done;

    assign w_last_read = (r_idx == LAST_IDX);
    assign w_wait_done = (r_wait_cnt == '0);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and state-decoded outputs
    always_comb begin
        w_next_state = r_state;
        req_ready    = 1'b0;
        mem_rd_en    = 1'b0;
        res_valid    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) w_next_state = ST_STREAM;
            end
            ST_STREAM: begin
                mem_rd_en = 1'b1;
                if (w_last_read) w_next_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (w_wait_done) w_next_state = ST_DONE;
            end
            ST_DONE: begin
                res_valid = 1'b1;
                if (res_ready) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx        <= '0;
            r_base       <= '0;
            r_wait_cnt   <= '0;
            r_dec_row    <= '0;
            r_res_data   <= '0;
            r_done_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_base <= req_ct_base;
                        r_idx  <= '0;
                    end
                end
                ST_STREAM: begin
                    // The row tag follows the read by one cycle so it lines up
                    // with rdata; it then holds until the next stream.
                    r_dec_row <= ROW_W'(r_idx);
                    if (w_last_read) begin
                        r_wait_cnt <= WAIT_LOAD;
                    end else begin
                        r_idx <= r_idx + ADDR_WIDTH'(1);
                    end
                end
                ST_WAIT: begin
                    // WAIT spans DECRYPT_LATENCY+1 cycles: one for the last
                    // rdata to arrive, then the datapath latency.
                    if (w_wait_done) begin
                        r_res_data   <= dec_result;
                        r_done_count <= r_done_count + 16'd1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign sk_addr     = r_idx;
    assign ct_addr     = r_base + r_idx;
    assign dec_skentry = sk_rdata;
    assign dec_ctentry = ct_rdata;
    assign dec_row     = r_dec_row;
    assign res_data    = r_res_data;
    assign done_count  = r_done_count;
    assign dbg_state   = r_state;

endmodule
